// File: rtl/fmrv32im_plic_pkg.sv
// Shared constants for the fmrv32im PLIC arbiter: register map, FSM encoding, ID width.
package fmrv32im_plic_pkg;

    localparam int ID_W = 6;

    localparam logic [3:0] ADDR_THRESH = 4'h0;
    localparam logic [3:0] ADDR_CLAIM  = 4'h1;
    localparam logic [3:0] ADDR_STATUS = 4'h2;
    localparam logic [3:0] ADDR_PRIO0  = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CLAIMED = 2'd2
    } state_t;

endpackage

// File: rtl/fmrv32im_plic_prio_tree.sv
// Combinational max-priority reduction; ties resolve to the lowest index, ID = index+1.
// Latency: 0 cycles (parent registers the result). No backpressure.
module fmrv32im_plic_prio_tree #(
    parameter int NUM_SRC = 32,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 6
) (
    input  logic [NUM_SRC-1:0]             elig,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    output logic [ID_W-1:0]                win_id,
    output logic [PRIO_W-1:0]              win_prio
);

    // Strict greater-than keeps the earliest source on equal priority.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && (prio[i] > win_prio)) begin
                win_id   = ID_W'(i + 1);
                win_prio = prio[i];
            end
        end
    end

endmodule

// File: rtl/fmrv32im_plic_arbiter.sv
// Priority arbiter and claim/complete sequencer between PLIC pending stage and CPU.
// Latency: pend -> win_id 1 cycle, -> ARMED/INT_OUT 2 cycles; one interrupt in service at a time.
module fmrv32im_plic_arbiter
    import fmrv32im_plic_pkg::*;
#(
    parameter int NUM_SRC = 32,
    parameter int PRIO_W  = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BUS_WE,
    input  logic               BUS_RE,
    input  logic [3:0]         BUS_ADDR,
    input  logic [31:0]        BUS_WDATA,
    output logic [31:0]        BUS_RDATA,
    input  logic [NUM_SRC-1:0] IRQ_PEND,
    output logic [NUM_SRC-1:0] IRQ_CLR,
    output logic               INT_OUT
);

    logic [PRIO_W-1:0]              thresh_q;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
    logic [ID_W-1:0]                win_id_q;
    logic [ID_W-1:0]                isr_id_q;
    logic [NUM_SRC-1:0]             irq_clr_q;
    state_t                         state_q;
    state_t                         state_d;

    logic [NUM_SRC-1:0]             elig;
    logic [ID_W-1:0]                tree_id;
    logic [PRIO_W-1:0]              unused_tree_prio;
    logic                           unused_wdata;
    logic [31:0]                    prio_rd;
    logic [NUM_SRC-1:0]             clr_onehot;

    logic claim_rd;
    logic claim_fire;
    logic complete_hit;

    assign unused_wdata = &{1'b0, BUS_WDATA};

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            elig[s] = IRQ_PEND[s] && (prio_q[s] > thresh_q);
        end
    end

    fmrv32im_plic_prio_tree #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_prio_tree (
        .elig     (elig),
        .prio     (prio_q),
        .win_id   (tree_id),
        .win_prio (unused_tree_prio)
    );

    assign claim_rd     = BUS_RE && (BUS_ADDR == ADDR_CLAIM);
    assign claim_fire   = (state_q == ST_ARMED) && claim_rd && (win_id_q != '0);
    assign complete_hit = (state_q == ST_CLAIMED) && BUS_WE && (BUS_ADDR == ADDR_CLAIM) &&
                          (BUS_WDATA[ID_W-1:0] == isr_id_q);

    always_comb begin
        clr_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_id_q == ID_W'(i + 1)) begin
                clr_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            thresh_q <= '0;
            prio_q   <= '0;
        end else if (BUS_WE) begin
            if (BUS_ADDR == ADDR_THRESH) begin
                thresh_q <= BUS_WDATA[PRIO_W-1:0];
            end
            // Only sources that exist get storage, so higher nibbles stay zero.
            for (int s = 0; s < NUM_SRC; s++) begin
                if (BUS_ADDR == (ADDR_PRIO0 + 4'(s / 8))) begin
                    prio_q[s] <= BUS_WDATA[(s % 8) * 4 +: PRIO_W];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            win_id_q  <= '0;
            isr_id_q  <= '0;
            irq_clr_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            win_id_q  <= tree_id;
            irq_clr_q <= claim_fire ? clr_onehot : '0;
            state_q   <= state_d;
            if (claim_fire) begin
                isr_id_q <= win_id_q;
            end else if (complete_hit) begin
                isr_id_q <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_id_q != '0) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (win_id_q == '0)  state_d = ST_IDLE;
                else if (claim_rd)   state_d = ST_CLAIMED;
            end
            ST_CLAIMED: begin
                if (complete_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prio_rd = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (BUS_ADDR == (ADDR_PRIO0 + 4'(s / 8))) begin
                prio_rd[(s % 8) * 4 +: PRIO_W] = prio_q[s];
            end
        end
    end

    // Reads reflect registered values, so a same-cycle write shows the old data.
    always_comb begin
        BUS_RDATA = prio_rd;
        case (BUS_ADDR)
            ADDR_THRESH: BUS_RDATA = 32'(thresh_q);
            ADDR_CLAIM:  BUS_RDATA = (state_q == ST_ARMED) ? 32'(win_id_q) : 32'd0;
            ADDR_STATUS: begin
                BUS_RDATA      = '0;
                BUS_RDATA[5:0] = isr_id_q;
                BUS_RDATA[9:8] = state_q;
            end
            default: ;
        endcase
    end

    assign IRQ_CLR = irq_clr_q;
    assign INT_OUT = (state_q == ST_ARMED);

endmodule
